seg_ascii_scan: RTL

- Parametrised multiplexed 7-segment ASCII display driver for N common-anode digits, with per-digit decimal points.
- Double-buffered character store: host writes are latched into a pending buffer and applied only at a frame boundary, so the display never tears.
- Single clock domain. Scan timing uses a clock-enable tick; no derived clocks.
- Includes per-slot anti-ghost blanking. Digit/letter/symbol decode is extended beyond the 0-9 set.

---
 rtl/seg_ascii_scan_if.sv | 28 ++
 rtl/seg_ascii_scan.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/seg_ascii_scan_if.sv
// seg_ascii_scan_if: host/display bus for the seg_ascii_scan display driver.
//   master (host side) drives : en, load, chars_in, dp_in, blink_mask
//   master (host side) reads  : seg_sel, seg_led, upd_pending, frame_done
//   slave  (driver side) is the mirror image.
// DIGITS must match the DIGITS parameter of the driver it is connected to.
interface seg_ascii_scan_if #(
  parameter int DIGITS = 6
);
  logic                  en;
  logic                  load;
  logic [8*DIGITS-1:0]   chars_in;
  logic [DIGITS-1:0]     dp_in;
  logic [DIGITS-1:0]     blink_mask;
  logic [DIGITS-1:0]     seg_sel;
  logic [7:0]            seg_led;
  logic                  upd_pending;
  logic                  frame_done;

  modport master (
    output en, load, chars_in, dp_in, blink_mask,
    input  seg_sel, seg_led, upd_pending, frame_done
  );

  modport slave (
    input  en, load, chars_in, dp_in, blink_mask,
    output seg_sel, seg_led, upd_pending, frame_done
  );
endinterface

// File: rtl/seg_ascii_scan.sv
// seg_ascii_scan: multiplexed common-anode 7-segment ASCII display driver.
//   Ports: clk (system clock), rst (synchronous, active-high),
//          bus (seg_ascii_scan_if.slave):
//            en          display enable
//            load        one-cycle write strobe for chars_in / dp_in
//            chars_in    ASCII per digit, byte k -> digit k (digit 0 rightmost)
//            dp_in       decimal point per digit, 1 = lit
//            blink_mask  per-digit blink request
//            seg_sel     digit select, active-low
//            seg_led     segments {h,g,f,e,d,c,b,a}, active-low
//            upd_pending pending buffer not yet applied
//            frame_done  one-cycle pulse after the last slot of a frame
//   Host writes land in a pending buffer and are copied to the active buffer
//   only at a frame boundary, so a frame never shows a mix of old/new text.
//   Optional build macro SEG_BLINK_EN: enables the blink frame counter;
//   without it blink_mask is ignored.
module seg_ascii_scan #(
  parameter int DIGITS       = 6,
  parameter int SCAN_DIV     = 50000,
  parameter int BLANK_CYC    = 4,
  parameter int BLINK_FRAMES = 128
) (
  input  logic           clk,
  input  logic           rst,
  seg_ascii_scan_if.slave bus
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam int IW = $clog2(DIGITS);
  localparam logic [CW-1:0] CNT_LAST  = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK_CYC);
  localparam logic [IW-1:0] IDX_LAST  = IW'(DIGITS - 1);

  // ASCII to active-low segment glyph; letters are folded to upper case.
  // 'O' reuses the '0' glyph so words like "hello" read naturally.
  function automatic logic [7:0] decode(input logic [7:0] c);
    logic [7:0] u;
    logic [7:0] g;
    if ((c >= 8'h61) && (c <= 8'h7A)) begin
      u = c - 8'h20;
    end else begin
      u = c;
    end
    case (u)
      8'h00, 8'h20: g = 8'hFF;
      8'h30, 8'h4F: g = 8'hC0;
      8'h31:        g = 8'hF9;
      8'h32:        g = 8'hA4;
      8'h33:        g = 8'hB0;
      8'h34:        g = 8'h99;
      8'h35:        g = 8'h92;
      8'h36:        g = 8'h82;
      8'h37:        g = 8'hF8;
      8'h38:        g = 8'h80;
      8'h39:        g = 8'h90;
      8'h41:        g = 8'h88;
      8'h42:        g = 8'h83;
      8'h43:        g = 8'hC6;
      8'h44:        g = 8'hA1;
      8'h45:        g = 8'h86;
      8'h46:        g = 8'h8E;
      8'h48:        g = 8'h89;
      8'h4C:        g = 8'hC7;
      8'h50:        g = 8'h8C;
      8'h55:        g = 8'hC1;
      8'h2D:        g = 8'hBF;
      8'h5F:        g = 8'hF7;
      default:      g = 8'hB6;
    endcase
    return g;
  endfunction

  logic [CW-1:0]         cnt_q, cnt_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [8*DIGITS-1:0]   act_chars_q, act_chars_d;
  logic [DIGITS-1:0]     act_dp_q, act_dp_d;
  logic [8*DIGITS-1:0]   pend_chars_q, pend_chars_d;
  logic [DIGITS-1:0]     pend_dp_q, pend_dp_d;
  logic                  upd_q, upd_d;
  logic                  fd_q, fd_d;
  logic [DIGITS-1:0]     sel_q, sel_d;
  logic [7:0]            led_q, led_d;

  logic                  tick_s;
  logic                  boundary_s;
  logic                  lit_s;
  logic                  dark_s;
  logic [7:0]            char_cur_s;
  logic [7:0]            glyph_s;

`ifdef SEG_BLINK_EN
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [FW-1:0] FCNT_LAST = FW'(BLINK_FRAMES - 1);
  logic [FW-1:0]         fcnt_q, fcnt_d;
  logic                  phase_q, phase_d;   // 1 = blinking digits visible
`else
  logic                  unused_blink_s;
  assign unused_blink_s = ^{bus.blink_mask, BLINK_FRAMES[0]};
`endif

  assign tick_s     = (cnt_q == CNT_LAST);
  assign boundary_s = tick_s && (idx_q == IDX_LAST);

  // Next-state logic: scan counters, buffer handover, output glyph.
  always_comb begin
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    act_chars_d  = act_chars_q;
    act_dp_d     = act_dp_q;
    pend_chars_d = pend_chars_q;
    pend_dp_d    = pend_dp_q;
    upd_d        = upd_q;
    fd_d         = boundary_s;
    sel_d        = sel_q;
    led_d        = led_q;
    dark_s       = 1'b0;

    if (tick_s) begin
      cnt_d = '0;
      if (idx_q == IDX_LAST) begin
        idx_d = '0;
      end else begin
        idx_d = idx_q + IW'(1);
      end
    end else begin
      cnt_d = cnt_q + CW'(1);
    end

    // A load on the boundary edge bypasses the pending buffer entirely.
    if (boundary_s) begin
      upd_d = 1'b0;
      if (bus.load) begin
        act_chars_d = bus.chars_in;
        act_dp_d    = bus.dp_in;
      end else if (upd_q) begin
        act_chars_d = pend_chars_q;
        act_dp_d    = pend_dp_q;
      end else begin
        act_chars_d = act_chars_q;
        act_dp_d    = act_dp_q;
      end
    end else if (bus.load) begin
      pend_chars_d = bus.chars_in;
      pend_dp_d    = bus.dp_in;
      upd_d        = 1'b1;
    end else begin
      upd_d        = upd_q;
    end

`ifdef SEG_BLINK_EN
    fcnt_d  = fcnt_q;
    phase_d = phase_q;
    if (boundary_s) begin
      if (fcnt_q == FCNT_LAST) begin
        fcnt_d  = '0;
        phase_d = ~phase_q;
      end else begin
        fcnt_d  = fcnt_q + FW'(1);
      end
    end else begin
      fcnt_d  = fcnt_q;
    end
    dark_s = ~phase_q & bus.blink_mask[idx_q];
`endif

    char_cur_s = act_chars_q[{idx_q, 3'b000} +: 8];
    glyph_s    = decode(char_cur_s);
    if (act_dp_q[idx_q]) begin
      glyph_s[7] = 1'b0;
    end else begin
      glyph_s[7] = glyph_s[7];
    end

    // Anti-ghost: all digits off for the first BLANK_CYC clocks of a slot.
    lit_s = bus.en && (cnt_q >= CNT_BLANK);
    if (!lit_s) begin
      sel_d = '1;
      led_d = 8'hFF;
    end else if (dark_s) begin
      sel_d = ~(DIGITS'(1) << idx_q);
      led_d = 8'hFF;
    end else begin
      sel_d = ~(DIGITS'(1) << idx_q);
      led_d = glyph_s;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q        <= '0;
      idx_q        <= '0;
      act_chars_q  <= '0;
      act_dp_q     <= '0;
      pend_chars_q <= '0;
      pend_dp_q    <= '0;
      upd_q        <= 1'b0;
      fd_q         <= 1'b0;
      sel_q        <= '1;
      led_q        <= 8'hFF;
`ifdef SEG_BLINK_EN
      fcnt_q       <= '0;
      phase_q      <= 1'b1;
`endif
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      act_chars_q  <= act_chars_d;
      act_dp_q     <= act_dp_d;
      pend_chars_q <= pend_chars_d;
      pend_dp_q    <= pend_dp_d;
      upd_q        <= upd_d;
      fd_q         <= fd_d;
      sel_q        <= sel_d;
      led_q        <= led_d;
`ifdef SEG_BLINK_EN
      fcnt_q       <= fcnt_d;
      phase_q      <= phase_d;
`endif
    end
  end

  assign bus.seg_sel     = sel_q;
  assign bus.seg_led     = led_q;
  assign bus.upd_pending = upd_q;
  assign bus.frame_done  = fd_q;

endmodule
